// File: rtl/result_frame_tx.sv
// Output-side frame transmitter: buffers FRAME_LEN two-channel result pairs, then
// streams header, length, payload and an 8-bit additive checksum over a valid/ready byte port.
module result_frame_tx #(
  parameter int         FRAME_LEN   = 36,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data_0,
  input  logic [7:0] in_data_1,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       frame_done,
  output logic       overflow
);

  localparam int IDX_W = 7;
  localparam int AW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int DEPTH = 2 ** AW;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [7:0]       LEN_BYTE = 8'(FRAME_LEN * 2);

  typedef enum logic [2:0] {COLLECT, HDR, LEN, PAY, CSUM} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             sel_q, sel_d;
  logic [7:0]       checksum_q, checksum_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q, overflow_d;

  logic [15:0]      buf_mem [DEPTH];
  logic [15:0]      rd_word_q;
  logic [IDX_W-1:0] rd_addr;

  logic xfer, accept, last_pair, pay_last;

  assign xfer      = tx_valid_q && tx_ready;
  assign accept    = in_valid && (state_q == COLLECT);
  assign last_pair = accept && (wr_idx_q == LAST_IDX);
  assign pay_last  = sel_q && (rd_idx_q == LAST_IDX);

  // The RAM read runs one entry ahead of the byte on the bus, so the next ch0
  // is already registered when the current ch1 transfers; ch1 is parked in hi_q.
  assign rd_addr = (state_q == PAY && rd_idx_q != LAST_IDX) ? rd_idx_q + IDX_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[wr_idx_q[AW-1:0]] <= {in_data_1, in_data_0};
    end
    rd_word_q <= buf_mem[rd_addr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (last_pair)        state_d = HDR;
      HDR:     if (xfer)             state_d = LEN;
      LEN:     if (xfer)             state_d = PAY;
      PAY:     if (xfer && pay_last) state_d = CSUM;
      CSUM:    if (xfer)             state_d = COLLECT;
      default:                       state_d = COLLECT;
    endcase
  end

  always_comb begin
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    sel_d        = sel_q;
    checksum_d   = checksum_q;
    hi_d         = hi_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q | (in_valid && state_q != COLLECT);
    case (state_q)
      COLLECT: begin
        if (accept) begin
          wr_idx_d = last_pair ? '0 : wr_idx_q + IDX_W'(1);
        end
        if (last_pair) begin
          tx_data_d  = HEADER_BYTE;
          tx_valid_d = 1'b1;
        end
      end
      HDR: begin
        if (xfer) tx_data_d = LEN_BYTE;
      end
      LEN: begin
        if (xfer) begin
          tx_data_d = rd_word_q[7:0];
          hi_d      = rd_word_q[15:8];
          sel_d     = 1'b0;
        end
      end
      PAY: begin
        if (xfer) begin
          checksum_d = checksum_q + tx_data_q;
          if (!sel_q) begin
            tx_data_d = hi_q;
            sel_d     = 1'b1;
          end else if (pay_last) begin
            tx_data_d = checksum_q + tx_data_q;
            sel_d     = 1'b0;
          end else begin
            tx_data_d = rd_word_q[7:0];
            hi_d      = rd_word_q[15:8];
            rd_idx_d  = rd_idx_q + IDX_W'(1);
            sel_d     = 1'b0;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          tx_valid_d   = 1'b0;
          frame_done_d = 1'b1;
          checksum_d   = '0;
          rd_idx_d     = '0;
          sel_d        = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      sel_q        <= 1'b0;
      checksum_q   <= '0;
      hi_q         <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      sel_q        <= sel_d;
      checksum_q   <= checksum_d;
      hi_q         <= hi_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign in_ready   = (state_q == COLLECT);
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_result_frame_tx.sv
// Bench for result_frame_tx: the driver pushes each frame's expected byte stream into a
// queue, and a negedge monitor pops and compares every transferred byte and flag.
module tb_result_frame_tx;

  localparam int N           = 2;
  localparam int NB          = 36;
  localparam int FRAME_BYTES = 2 * N + 3;
  localparam int TIMEOUT     = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data_0 = '0, in_data_1 = '0;
  logic       tx_ready = 1'b0;
  logic       in_ready, tx_valid, frame_done, overflow;
  logic [7:0] tx_data;

  logic       b_in_valid = 1'b0;
  logic [7:0] b_d0 = '0, b_d1 = '0;
  logic       b_tx_ready = 1'b1;
  logic       b_in_ready, b_tx_valid, b_frame_done, b_overflow;
  logic [7:0] b_tx_data;

  result_frame_tx #(.FRAME_LEN(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data_0(in_data_0),
    .in_data_1(in_data_1), .in_ready(in_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .frame_done(frame_done), .overflow(overflow)
  );

  result_frame_tx #(.FRAME_LEN(NB)) dut36 (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data_0(b_d0),
    .in_data_1(b_d1), .in_ready(b_in_ready), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_ready(b_tx_ready), .frame_done(b_frame_done), .overflow(b_overflow)
  );

  int checks = 0;
  int fails  = 0;

  function automatic void check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endfunction

  // Reference model state, advanced once per cycle by the monitor.
  bit         busy = 0, ovf_m = 0, fd_m = 0;
  int         pair_cnt = 0, byte_pos = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp36[$];
  logic [15:0] pend[$];
  bit         b_active = 0;
  int         b_got = 0;

  always @(negedge clk) begin
    if (reset) begin
      busy = 0; ovf_m = 0; fd_m = 0; pair_cnt = 0; byte_pos = 0;
    end else begin
      check("in_ready", in_ready, int'(!busy));
      check("tx_valid", tx_valid, int'(busy));
      check("overflow", overflow, int'(ovf_m));
      check("frame_done", frame_done, int'(fd_m));
      fd_m = 0;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL tx_byte: got 0x%02h, required no byte", tx_data);
        end else begin
          check("tx_byte", tx_data, exp_q.pop_front());
        end
      end else if (busy && !tx_ready && exp_q.size() > 0) begin
        check("tx_hold", tx_data, exp_q[0]);
      end
      if (busy) begin
        if (in_valid) ovf_m = 1;
        if (tx_ready) begin
          byte_pos++;
          if (byte_pos == FRAME_BYTES) begin
            busy = 0; byte_pos = 0; fd_m = 1;
          end
        end
      end else if (in_valid) begin
        pair_cnt++;
        if (pair_cnt == N) begin
          pair_cnt = 0; busy = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b_active) begin
      check("in_ready36", b_in_ready, 0);
      check("tx_valid36", b_tx_valid, 1);
      if (b_tx_valid && b_tx_ready) begin
        if (exp36.size() == 0) begin
          checks++; fails++;
          $display("FAIL tx_byte36: got 0x%02h, required no byte", b_tx_data);
        end else begin
          check("tx_byte36", b_tx_data, exp36.pop_front());
        end
        b_got++;
        if (b_got == 2 * NB + 3) b_active = 0;
      end
    end
  end

  bit rnd_ready = 0, bp_mode = 0;
  int stall_left = 0, prev_pos = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_mode && byte_pos != prev_pos && (byte_pos == 1 || byte_pos == 4)) stall_left = 5;
      prev_pos = byte_pos;
      if (stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
      end else begin
        tx_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_frame(input logic [15:0] pairs[$], input bit big);
    logic [7:0] b[$];
    int sum;
    sum = 0;
    b.push_back(8'hA5);
    b.push_back(8'(2 * pairs.size()));
    foreach (pairs[i]) begin
      b.push_back(pairs[i][7:0]);
      b.push_back(pairs[i][15:8]);
      sum += int'(pairs[i][7:0]) + int'(pairs[i][15:8]);
    end
    b.push_back(8'(sum % 256));
    foreach (b[i]) begin
      if (big) exp36.push_back(b[i]);
      else     exp_q.push_back(b[i]);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < TIMEOUT) begin tick(); n++; end
    if (busy) begin
      checks++; fails++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", TIMEOUT);
    end
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while (byte_pos != p && n < TIMEOUT) begin tick(); n++; end
    if (byte_pos != p) begin
      checks++; fails++;
      $display("FAIL wait_pos: byte position %0d, required %0d", byte_pos, p);
    end
  endtask

  task automatic send_pair(input logic [7:0] d0, input logic [7:0] d1);
    wait_idle();
    in_valid = 1'b1; in_data_0 = d0; in_data_1 = d1;
    pend.push_back({d1, d0});
    if (pend.size() == N) begin
      push_frame(pend, 1'b0);
      pend.delete();
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drop_pair();
    in_valid = 1'b1; in_data_0 = 8'($urandom); in_data_1 = 8'($urandom);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    pend.delete(); exp_q.delete();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_big(input bit all_ff);
    logic [15:0] pq[$];
    int n;
    for (int i = 0; i < NB; i++) begin
      b_in_valid = 1'b1;
      b_d0 = all_ff ? 8'hFF : 8'($urandom);
      b_d1 = all_ff ? 8'hFF : 8'($urandom);
      pq.push_back({b_d1, b_d0});
      tick();
    end
    b_in_valid = 1'b0;
    push_frame(pq, 1'b1);
    b_got = 0; b_active = 1;
    n = 0;
    while (b_active && n < TIMEOUT) begin tick(); n++; end
    if (b_active) begin
      checks++; fails++;
      $display("FAIL big_frame: %0d bytes seen, required %0d", b_got, 2 * NB + 3);
      b_active = 0;
    end else begin
      check("frame_done36", b_frame_done, 1);
      check("in_ready36_after", b_in_ready, 1);
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_overflow", overflow, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_in_ready36", b_in_ready, 1);

    send_pair(8'h10, 8'h20); send_pair(8'h30, 8'h40);
    wait_idle(); tick();

    bp_mode = 1;
    send_pair(8'h10, 8'h20); send_pair(8'h30, 8'h40);
    wait_idle(); tick();
    bp_mode = 0;

    send_pair(8'($urandom), 8'($urandom)); send_pair(8'($urandom), 8'($urandom));
    wait_pos(5);
    drop_pair();
    wait_idle();
    send_pair(8'hC3, 8'h3C); send_pair(8'h99, 8'h66);
    wait_idle(); tick();

    send_pair(8'h55, 8'h66); send_pair(8'h77, 8'h88);
    wait_pos(3);
    do_reset();
    send_pair(8'h01, 8'h02); send_pair(8'h03, 8'h04);
    wait_idle();

    for (int k = 0; k < 2 * N; k++) send_pair(8'($urandom), 8'($urandom));
    for (int k = 0; k < 2 * N; k++) send_pair(8'($urandom), 8'($urandom));
    wait_idle();

    rnd_ready = 1;
    for (int k = 0; k < 80; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        if (busy && $urandom_range(0, 5) == 0) drop_pair();
        else tick();
      end
      send_pair(8'($urandom), 8'($urandom));
    end
    wait_idle();
    rnd_ready = 0;
    tick(); tick();

    send_big(1'b1);
    send_big(1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/result_frame_tx.md
Name: result_frame_tx

Overview:
Output-side transmitter for the CNN pipeline. The input side loads one pixel per cycle over the 8-bit pin bus. This block is the opposite end: it collects the per-position two-channel results produced by the final layer. It buffers one full frame of results, then streams them out byte-serially on the 8-bit output pins with a valid/ready handshake. Each frame is sent as header, length, payload and checksum, so an off-chip reader can delimit and validate frames.

Parameters:
FRAME_LEN, 36, number of result pairs (output positions) per frame; legal range 1..127.
HEADER_BYTE, 8'hA5, constant frame-start marker.

Ports:
clk  input  1  clock.
reset  input  1  reset; synchronous, active-high.
in_valid  input  1  one-cycle strobe; in_data_0/in_data_1 hold a result pair.
in_data_0  input  8  channel-0 result.
in_data_1  input  8  channel-1 result.
in_ready  output  1  high while the block accepts pairs (COLLECT state).
tx_data  output  8  serial byte out; registered.
tx_valid  output  1  tx_data holds a byte to transfer; registered.
tx_ready  input  1  downstream accepts the byte when high together with tx_valid.
frame_done  output  1  one-cycle pulse after the checksum byte is accepted.
overflow  output  1  sticky; a pair arrived while in_ready was low.

Behaviour:
- Reset values: state COLLECT, wr_idx=0, rd_idx=0, checksum=0. Outputs: tx_data=0, tx_valid=0, frame_done=0, overflow=0. in_ready is combinational, so it is 1 after reset. Reset mid-frame discards all buffered and partially sent data. Buffer contents need no reset.
- Storage: FRAME_LEN x 16-bit buffer. The entry layout is {in_data_1, in_data_0}.
- States: COLLECT -> HDR -> LEN -> PAY -> CSUM -> COLLECT.
- COLLECT:
  - in_ready=1, tx_valid=0.
  - On in_valid, write the pair at wr_idx and increment wr_idx.
  - When the pair written is the FRAME_LEN-th: wr_idx returns to 0, state goes to HDR, and on that same edge tx_data=HEADER_BYTE and tx_valid=1.
  - The first header byte is therefore visible the cycle after the last pair is accepted (1-cycle latency).
- Byte transfer:
  - A byte transfers on a clk edge where tx_valid and tx_ready are both high.
  - While tx_ready is low, tx_data and tx_valid hold stable; there is no timeout.
  - The next byte loads on the transfer edge, so back-to-back transfers run at 1 byte/cycle.
- HDR: after transfer, tx_data = FRAME_LEN*2 (the number of payload bytes) and state goes to LEN.
- LEN: after transfer, tx_data = ch0 of entry 0 and state goes to PAY.
- PAY:
  - Byte order is entry0.ch0, entry0.ch1, entry1.ch0, ... up to entry(FRAME_LEN-1).ch1.
  - A byte-select bit toggles each transfer; rd_idx increments after a ch1 byte.
  - Every payload byte transferred is added to checksum, which is 8 bits and wraps modulo 256.
  - After the final ch1 transfers, tx_data = checksum including that byte, and state goes to CSUM.
- CSUM: after transfer, tx_valid=0, frame_done=1 for one cycle, checksum=0, rd_idx=0, and state goes to COLLECT.
- Header and length bytes are not included in the checksum.
- Overflow: in_valid while not in COLLECT drops the pair and sets overflow=1. Overflow stays set until reset; the current frame is unaffected.
- Simultaneous events:
  - in_valid on the edge that leaves CSUM is dropped (in_ready was low), and overflow is set.
  - in_valid on the edge that enters HDR is accepted, because it is the last pair.
- tx_ready is ignored while tx_valid=0.

Test Plan:
1. FRAME_LEN=2, tx_ready=1, pairs (0x10,0x20),(0x30,0x40) -> bytes A5,04,10,20,30,40,A0 on 7 consecutive cycles. tx_valid rises the cycle after the 2nd pair; frame_done pulses the cycle after A0.
2. Default FRAME_LEN=36, all pairs (0xFF,0xFF) -> A5,48, then 72 bytes of FF, then checksum B8; in_ready=0 from HDR through CSUM.
3. Backpressure, FRAME_LEN=2 with the case-1 data: hold tx_ready=0 for 5 cycles at each of LEN and PAY byte 3 -> tx_data stays 04 / 30 with tx_valid=1. The byte sequence is identical to case 1 and no byte is lost or duplicated.
4. Overflow: in_valid pulse during PAY -> overflow=1 and stays 1. The frame checksum is unchanged. The next frame is collected from its first pair normally.
5. Reset asserted during PAY after 3 bytes -> next cycle tx_valid=0, in_ready=1, overflow=0. A new frame (0x01,0x02),(0x03,0x04) then sends A5,04,01,02,03,04,0A.
6. Two frames back-to-back with pairs arriving the cycle in_ready rises -> second frame is accepted; its checksum starts from 0 (not carried over).
